// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared definitions for the APB request arbiter: controller state encoding,
// slave-select codes driven on Psel, and the error flag value returned on
// rsp_err. sel_legal() tells whether a requester's slave code maps to a slave.
// ---------------------------------------------------------------------------
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_GPIO = 2'd1;
    localparam logic [1:0] SEL_UART = 2'd2;

    localparam logic ERR_FLAG = 1'b1;

    function automatic logic sel_legal(input logic [1:0] sel);
        return (sel == SEL_GPIO) || (sel == SEL_UART);
    endfunction

endpackage

// File: rtl/apb_req_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first set request bit found
// scanning ptr, ptr+1, ... (mod NUM_REQ). No state.
// Ports:
//   req      in   NUM_REQ  pending request bits
//   ptr      in   IDX_W    highest-priority index this round
//   grant    out  IDX_W    chosen requester (0 when none pending)
//   any_req  out  1        at least one request pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    int unsigned off;
    int unsigned best_off;

    // Distance of each requester from ptr in scan order; smallest distance wins.
    always_comb begin
        grant    = '0;
        off      = 0;
        best_off = NUM_REQ;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            off = (i + NUM_REQ - 32'(ptr)) % NUM_REQ;
            if (req[i] && (off < best_off)) begin
                best_off = off;
                grant    = IDX_W'(i);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
// Shares one APB master between NUM_REQ requesters. Grants one command at a
// time in round-robin order, drives the master's transfer/pwrite/Psel/address/
// data inputs, detects completion (penable && pready), returns read data and
// aborts with an error on timeout or on an illegal slave select.
// Ports:
//   pclk, Reset                 clock, synchronous active-high reset
//   req_valid/req_write         per-requester command pending / direction
//   req_sel/req_addr/req_wdata  per-requester slave code, address, write data
//   req_ready                   one-cycle accept pulse to the granted requester
//   rsp_valid/rsp_err/rsp_rdata one-cycle completion pulse, error, read data
//   transfer/pwrite/Psel        to master: sequence control and slave select
//   write_paddr/read_paddr      to master: address for write / read commands
//   write_data                  to master: write data
//   penable/pready/prdata       ACCESS phase from master, slave response
// ---------------------------------------------------------------------------
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                      pclk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [2*NUM_REQ-1:0]      req_sel,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      transfer,
    output logic                      pwrite,
    output logic [1:0]                Psel,
    output logic [ADDR_W-1:0]         write_paddr,
    output logic [ADDR_W-1:0]         read_paddr,
    output logic [DATA_W-1:0]         write_data,
    input  logic                      penable,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic               wr_q, wr_d;
    logic [1:0]         sel_q, sel_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               transfer_q, transfer_d;
    logic               pwrite_q, pwrite_d;
    logic [1:0]         psel_q, psel_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic [DATA_W-1:0]  wdout_q, wdout_d;

    logic [IDX_W-1:0]   grant;
    logic               any_req;
    logic [1:0]         sel_a   [NUM_REQ];
    logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_a [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .grant   (grant),
        .any_req (any_req)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel_a[i]   = req_sel[2*i +: 2];
            addr_a[i]  = req_addr[ADDR_W*i +: ADDR_W];
            wdata_a[i] = req_wdata[DATA_W*i +: DATA_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        g_d        = g_q;
        wr_d       = wr_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        transfer_d = transfer_q;
        pwrite_d   = pwrite_q;
        psel_d     = psel_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        wdout_d    = wdout_q;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_err    = 1'b0;
        rsp_rdata  = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    g_d     = grant;
                    wr_d    = req_write[grant];
                    sel_d   = sel_a[grant];
                    addr_d  = addr_a[grant];
                    wdata_d = wdata_a[grant];
                    err_d   = 1'b0;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                req_ready[g_q] = 1'b1;
                if (sel_legal(sel_q)) begin
                    transfer_d = 1'b1;
                    pwrite_d   = wr_q;
                    psel_d     = sel_q;
                    if (wr_q) begin
                        waddr_d = addr_q;
                        wdout_d = wdata_q;
                    end else begin
                        raddr_d = addr_q;
                    end
                    state_d = ST_WAIT;
                end else begin
                    err_d   = ERR_FLAG;
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                // Completion is tested before the timeout so it wins on the last cycle.
                if (penable && pready) begin
                    if (!pwrite_q) begin
                        rdata_d = prdata;
                    end
                    transfer_d = 1'b0;
                    pwrite_d   = 1'b0;
                    psel_d     = SEL_NONE;
                    state_d    = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    transfer_d = 1'b0;
                    pwrite_d   = 1'b0;
                    psel_d     = SEL_NONE;
                    err_d      = ERR_FLAG;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid[g_q] = 1'b1;
                rsp_err        = err_q;
                rsp_rdata      = rdata_q;
                rr_ptr_d       = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                cnt_d          = '0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            g_q        <= '0;
            wr_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            transfer_q <= 1'b0;
            pwrite_q   <= 1'b0;
            psel_q     <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            wdout_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            g_q        <= g_d;
            wr_q       <= wr_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            transfer_q <= transfer_d;
            pwrite_q   <= pwrite_d;
            psel_q     <= psel_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            wdout_q    <= wdout_d;
        end
    end

    assign transfer    = transfer_q;
    assign pwrite      = pwrite_q;
    assign Psel        = psel_q;
    assign write_paddr = waddr_q;
    assign read_paddr  = raddr_q;
    assign write_data  = wdout_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
// Directed and random commands from two requesters, an APB master/slave model
// driving penable/pready/prdata, and a transaction-level reference: expected
// grant from round-robin over pending requesters, expected result from the
// command's slave code and the slave's wait-state count.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    typedef struct packed {
        logic          wr;
        logic [1:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [31:0]   waits;
        logic [DW-1:0] rdata;
    } cmd_t;

    logic              pclk = 1'b0;
    logic              Reset;
    logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
    logic [2*NR-1:0]   req_sel;
    logic [AW*NR-1:0]  req_addr;
    logic [DW*NR-1:0]  req_wdata;
    logic              rsp_err, transfer, pwrite, penable, pready;
    logic [DW-1:0]     rsp_rdata, write_data, prdata;
    logic [1:0]        Psel;
    logic [AW-1:0]     write_paddr, read_paddr;

    always #5 pclk = ~pclk;

    apb_req_arbiter #(
        .NUM_REQ     (NR),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .pclk        (pclk),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_sel     (req_sel),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .transfer    (transfer),
        .pwrite      (pwrite),
        .Psel        (Psel),
        .write_paddr (write_paddr),
        .read_paddr  (read_paddr),
        .write_data  (write_data),
        .penable     (penable),
        .pready      (pready),
        .prdata      (prdata)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    cmd_t        cq [NR][$];
    logic [NR-1:0] active;
    cmd_t        infl;
    logic        busy, m_idle, exp_ready_next, tr_prev;
    int unsigned g_cur, mptr, xfer_len, acc, cur_waits;
    int          ready_cyc;
    logic [DW-1:0] cur_rdata;
    int          glog [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input logic wr, input logic [1:0] sel, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input int unsigned w, input logic [DW-1:0] rd);
        cmd_t c;
        c.wr = wr; c.sel = sel; c.addr = a; c.wdata = d; c.waits = w; c.rdata = rd;
        return c;
    endfunction

    function automatic logic legal(input logic [1:0] s);
        return (s == 2'd1) || (s == 2'd2);
    endfunction

    // Cycles transfer stays high: SETUP + (waits+1) ACCESS cycles, capped by the timeout.
    function automatic int unsigned exp_len(input cmd_t c);
        if (!legal(c.sel)) return 0;
        return (c.waits + 2 > TO) ? TO : c.waits + 2;
    endfunction

    function automatic logic exp_err(input cmd_t c);
        return !legal(c.sel) || (c.waits + 2 > TO);
    endfunction

    function automatic logic [DW-1:0] exp_rdata(input cmd_t c);
        return (exp_err(c) || c.wr) ? '0 : c.rdata;
    endfunction

    task automatic check_cycle(output logic rsp_now);
        int unsigned r, eg;
        rsp_now = 1'b0;
        chk("ready_timing", 32'(|req_ready), 32'(exp_ready_next));
        chk("ready_rsp_overlap", 32'(|req_ready && |rsp_valid), 0);
        if (|req_ready) begin
            chk("ready_onehot", 32'($onehot(req_ready)), 1);
            r = 0;
            for (int i = 0; i < NR; i++) if (req_ready[i]) r = i;
            eg = NR;
            for (int unsigned k = 0; k < NR; k++)
                if (eg == NR && req_valid[(mptr + k) % NR]) eg = (mptr + k) % NR;
            chk("grant", r, eg);
            chk("grant_while_busy", 32'(busy), 0);
            chk("xfer_at_accept", 32'(transfer), 0);
            if (cq[r].size() > 0) infl = cq[r].pop_front();
            active[r] = 1'b0; req_valid[r] = 1'b0;
            busy = 1'b1; g_cur = r; ready_cyc = cyc; xfer_len = 0; m_idle = 1'b0;
            cur_waits = infl.waits; cur_rdata = infl.rdata;
            glog.push_back(int'(r));
        end
        if (transfer) begin
            chk("xfer_owner", 32'(busy && legal(infl.sel)), 1);
            xfer_len++;
            chk("psel", 32'(Psel), 32'(infl.sel));
            chk("pwrite", 32'(pwrite), 32'(infl.wr));
            if (infl.wr) begin
                chk("write_paddr", 32'(write_paddr), 32'(infl.addr));
                chk("write_data", write_data, infl.wdata);
            end else begin
                chk("read_paddr", 32'(read_paddr), 32'(infl.addr));
            end
        end else begin
            chk("psel_idle", 32'(Psel), 0);
        end
        if (|rsp_valid) begin
            chk("rsp_onehot", 32'($onehot(rsp_valid)), 1);
            r = 0;
            for (int i = 0; i < NR; i++) if (rsp_valid[i]) r = i;
            chk("rsp_busy", 32'(busy), 1);
            chk("rsp_owner", r, g_cur);
            chk("rsp_err", 32'(rsp_err), 32'(exp_err(infl)));
            chk("rsp_rdata", rsp_rdata, exp_rdata(infl));
            chk("xfer_len", xfer_len, exp_len(infl));
            chk("rsp_latency", 32'(cyc - ready_cyc), exp_len(infl) + 1);
            busy = 1'b0; mptr = (g_cur + 1) % NR; rsp_now = 1'b1;
        end else begin
            chk("err_idle", 32'(rsp_err), 0);
        end
    endtask

    task automatic master_model();
        if (transfer && tr_prev) begin
            penable = 1'b1; acc++; pready = (acc > cur_waits);
        end else begin
            penable = 1'b0; acc = 0; pready = 1'b0;
        end
        tr_prev = transfer;
        prdata  = pready ? cur_rdata : $urandom();
    endtask

    task automatic drive_reqs();
        cmd_t c;
        for (int r = 0; r < NR; r++) begin
            if (!active[r] && cq[r].size() > 0) begin
                c = cq[r][0];
                req_valid[r]          = 1'b1;
                req_write[r]          = c.wr;
                req_sel[r*2 +: 2]     = c.sel;
                req_addr[r*AW +: AW]  = c.addr;
                req_wdata[r*DW +: DW] = c.wdata;
                active[r]             = 1'b1;
            end
        end
    endtask

    task automatic step();
        logic rsp_now;
        @(negedge pclk);
        cyc++;
        rsp_now = 1'b0;
        if (Reset) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_err", 32'(rsp_err), 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_transfer", 32'(transfer), 0);
            chk("rst_pwrite", 32'(pwrite), 0);
            chk("rst_psel", 32'(Psel), 0);
            chk("rst_write_paddr", 32'(write_paddr), 0);
            chk("rst_read_paddr", 32'(read_paddr), 0);
            chk("rst_write_data", write_data, 0);
            // The aborted command is re-issued by its requester.
            if (busy) cq[g_cur].push_front(infl);
            busy = 1'b0; mptr = 0; m_idle = 1'b1;
            active = '0; req_valid = '0;
            Reset = 1'b0;
        end else begin
            check_cycle(rsp_now);
        end
        master_model();
        drive_reqs();
        exp_ready_next = m_idle && (|req_valid);
        if (rsp_now) m_idle = 1'b1;
    endtask

    task automatic drain(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            done = !busy && (active == '0) && (cq[0].size() == 0) && (cq[1].size() == 0);
        end
        chk("drain_done", 32'(done), 1);
    endtask

    initial begin
        logic [1:0] sels [6];
        sels = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd3};
        Reset = 1'b1;
        req_valid = '0; req_write = '0; req_sel = '0; req_addr = '0; req_wdata = '0;
        penable = 1'b0; pready = 1'b0; prdata = '0;
        active = '0; busy = 1'b0; m_idle = 1'b1; exp_ready_next = 1'b0; tr_prev = 1'b0;
        g_cur = 0; mptr = 0; xfer_len = 0; acc = 0; cur_waits = 0; cur_rdata = '0; ready_cyc = 0;
        infl = '0;
        step();
        step();

        // Single write, no wait states.
        cq[0].push_back(mk(1'b1, 2'd1, 5'h04, 32'hA5A5_0001, 0, 32'h0));
        drain(50);

        // Read with 3 wait states from requester 1.
        cq[1].push_back(mk(1'b0, 2'd2, 5'h10, 32'h0, 3, 32'h0000_00C3));
        drain(50);

        // Contention: both requesters pending for two commands each.
        glog.delete();
        for (int i = 0; i < 2; i++) begin
            cq[0].push_back(mk(1'b1, 2'd1, 5'(i + 1), $urandom(), 0, 32'h0));
            cq[1].push_back(mk(1'b0, 2'd2, 5'(i + 8), 32'h0, 1, $urandom()));
        end
        drain(200);
        chk("cont_count", 32'(glog.size()), 4);
        for (int i = 0; i < glog.size() && i < 4; i++) chk("cont_order", 32'(glog[i]), 32'(i % 2));

        // Timeout: pready never arrives.
        cq[0].push_back(mk(1'b0, 2'd1, 5'h03, 32'h0, 1000, 32'hDEAD_BEEF));
        drain(100);

        // Illegal slave codes.
        cq[0].push_back(mk(1'b1, 2'd3, 5'h07, 32'h1111_2222, 0, 32'h0));
        cq[1].push_back(mk(1'b0, 2'd0, 5'h09, 32'h0, 0, 32'h5555_AAAA));
        drain(50);

        // Completion on the last WAIT cycle, then one cycle too late.
        cq[1].push_back(mk(1'b0, 2'd2, 5'h1F, 32'h0, TO - 2, 32'h0BAD_F00D));
        drain(100);
        cq[1].push_back(mk(1'b0, 2'd2, 5'h1E, 32'h0, TO - 1, 32'h0BAD_F00E));
        drain(100);

        // Reset while waiting on the slave; the command is then re-issued.
        cq[1].push_back(mk(1'b1, 2'd2, 5'h0A, 32'h1234_5678, 6, 32'h0));
        for (int i = 0; i < 10 && !transfer; i++) step();
        chk("rst_test_xfer", 32'(transfer), 1);
        step();
        step();
        Reset = 1'b1;
        step();
        drain(100);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            cq[$urandom_range(0, NR - 1)].push_back(mk($urandom_range(0, 1) == 1,
                sels[$urandom_range(0, 5)], 5'($urandom()), $urandom(),
                ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 3, TO + 4) : $urandom_range(0, 4),
                $urandom()));
        end
        drain(3000);
        for (int i = 0; i < 3; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
